// File: rtl/sprite_motion.sv
// sprite_motion: frame-rate motion controller for one on-screen sprite.
// Arrow-style keycodes set the velocity, space toggles pause on its rising
// edge, and each axis handles its screen walls by bouncing, stopping or
// wrapping. Motion decided on an edge is applied on that same edge.
module sprite_motion #(
    parameter int WIDTH    = 10,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 240,
    parameter int SIZE     = 4,
    parameter int STEP     = 1
) (
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [7:0]       keycode,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] pos_x,
    output logic [WIDTH-1:0] pos_y,
    output logic [WIDTH-1:0] vel_x,
    output logic [WIDTH-1:0] vel_y,
    output logic [WIDTH-1:0] size,
    output logic             hit_x,
    output logic             hit_y,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MOVING = 2'b01,
        PAUSED = 2'b10
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] pos;
        logic [WIDTH-1:0] vel;
        logic             hit;
    } axis_t;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [WIDTH-1:0] VEL_POS = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] VEL_NEG = WIDTH'(-STEP);

    // Wall limits for the sprite centre, held two bits wider than a
    // position so that a step below zero compares as negative.
    localparam logic signed [WIDTH+1:0] X_LO = (WIDTH+2)'(X_MIN + SIZE);
    localparam logic signed [WIDTH+1:0] X_HI = (WIDTH+2)'(X_MAX - SIZE);
    localparam logic signed [WIDTH+1:0] Y_LO = (WIDTH+2)'(Y_MIN + SIZE);
    localparam logic signed [WIDTH+1:0] Y_HI = (WIDTH+2)'(Y_MAX - SIZE);

    state_t           state_q;
    logic [7:0]       prev_key;
    logic             is_dir;
    logic             space_edge;
    logic [WIDTH-1:0] key_vx;
    logic [WIDTH-1:0] key_vy;
    logic [WIDTH-1:0] vel_cx;
    logic [WIDTH-1:0] vel_cy;
    axis_t            next_x;
    axis_t            next_y;

    // One axis step: advance by the velocity, then apply the wall rule.
    // A wall only acts when the velocity actually points at it.
    function automatic axis_t wall_step(
        input logic [WIDTH-1:0]        pos,
        input logic [WIDTH-1:0]        vel,
        input logic [1:0]              wall_mode,
        input logic signed [WIDTH+1:0] lo,
        input logic signed [WIDTH+1:0] hi
    );
        axis_t                  r;
        logic signed [WIDTH+1:0] nxt;
        logic                   toward_hi;
        logic                   toward_lo;
        nxt       = $signed({2'b00, pos}) + $signed({{2{vel[WIDTH-1]}}, vel});
        toward_hi = !vel[WIDTH-1] && (vel != '0);
        toward_lo = vel[WIDTH-1];
        r.pos     = nxt[WIDTH-1:0];
        r.vel     = vel;
        r.hit     = 1'b0;
        case (wall_mode)
            2'b10: begin
                if (toward_hi && nxt > hi) begin
                    r.pos = lo[WIDTH-1:0];
                    r.hit = 1'b1;
                end else if (toward_lo && nxt < lo) begin
                    r.pos = hi[WIDTH-1:0];
                    r.hit = 1'b1;
                end
            end
            2'b01: begin
                if (toward_hi && nxt >= hi) begin
                    r.pos = hi[WIDTH-1:0];
                    r.vel = '0;
                    r.hit = 1'b1;
                end else if (toward_lo && nxt <= lo) begin
                    r.pos = lo[WIDTH-1:0];
                    r.vel = '0;
                    r.hit = 1'b1;
                end
            end
            default: begin
                if (toward_hi && nxt >= hi) begin
                    r.pos = hi[WIDTH-1:0];
                    r.vel = VEL_NEG;
                    r.hit = 1'b1;
                end else if (toward_lo && nxt <= lo) begin
                    r.pos = lo[WIDTH-1:0];
                    r.vel = VEL_POS;
                    r.hit = 1'b1;
                end
            end
        endcase
        return r;
    endfunction

    // Decode the keycode and compute both candidate next-axis states.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        is_dir = 1'b1;
        key_vx = '0;
        key_vy = '0;
        case (keycode)
            KEY_LEFT:  key_vx = VEL_NEG;
            KEY_RIGHT: key_vx = VEL_POS;
            KEY_UP:    key_vy = VEL_NEG;
            KEY_DOWN:  key_vy = VEL_POS;
            default:   is_dir = 1'b0;
        endcase
        space_edge = (keycode == KEY_SPACE) && (prev_key != KEY_SPACE);
        vel_cx     = is_dir ? key_vx : vel_x;
        vel_cy     = is_dir ? key_vy : vel_y;
        next_x     = wall_step(pos_x, vel_cx, mode, X_LO, X_HI);
        next_y     = wall_step(pos_y, vel_cy, mode, Y_LO, Y_HI);
    end

    // Frame-rate state machine with registered position, velocity and hit pulses.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            prev_key <= '0;
            pos_x    <= WIDTH'(X_CENTER);
            pos_y    <= WIDTH'(Y_CENTER);
            vel_x    <= '0;
            vel_y    <= '0;
            hit_x    <= 1'b0;
            hit_y    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            prev_key <= keycode;
            hit_x    <= 1'b0;
            hit_y    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_dir) begin
                        pos_x   <= next_x.pos;
                        vel_x   <= next_x.vel;
                        hit_x   <= next_x.hit;
                        pos_y   <= next_y.pos;
                        vel_y   <= next_y.vel;
                        hit_y   <= next_y.hit;
                        state_q <= MOVING;
                    end
                end
                MOVING: begin
                    if (space_edge) begin
                        state_q <= PAUSED;
                    end else begin
                        pos_x <= next_x.pos;
                        vel_x <= next_x.vel;
                        hit_x <= next_x.hit;
                        pos_y <= next_y.pos;
                        vel_y <= next_y.vel;
                        hit_y <= next_y.hit;
                    end
                end
                PAUSED: begin
                    if (space_edge) begin
                        state_q <= MOVING;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state = state_q;
    assign size  = WIDTH'(SIZE);

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: one instance at the default step of 1
// and one at step 3 placed near the walls, sharing clock and reset.
module tb_sprite_motion;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] key1, key3;
    logic [1:0] mode1, mode3;

    logic [9:0] pos_x1, pos_y1, vel_x1, vel_y1, size1;
    logic       hit_x1, hit_y1;
    logic [1:0] state1;
    logic [9:0] pos_x3, pos_y3, vel_x3, vel_y3, size3;
    logic       hit_x3, hit_y3;
    logic [1:0] state3;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [9:0] V_NEG1 = 10'h3FF;
    localparam logic [9:0] V_NEG3 = 10'h3FD;

    sprite_motion dut1 (
        .Reset(Reset), .frame_clk(frame_clk), .keycode(key1), .mode(mode1),
        .pos_x(pos_x1), .pos_y(pos_y1), .vel_x(vel_x1), .vel_y(vel_y1),
        .size(size1), .hit_x(hit_x1), .hit_y(hit_y1), .state(state1)
    );

    sprite_motion #(.STEP(3), .X_CENTER(621), .Y_CENTER(14)) dut3 (
        .Reset(Reset), .frame_clk(frame_clk), .keycode(key3), .mode(mode3),
        .pos_x(pos_x3), .pos_y(pos_y3), .vel_x(vel_x3), .vel_y(vel_y3),
        .size(size3), .hit_x(hit_x3), .hit_y(hit_y3), .state(state3)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one frame; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    initial begin
        int idle_bad;
        int n;
        Reset = 1'b0;
        key1  = 8'h00;
        key3  = 8'h00;
        mode1 = 2'b00;
        mode3 = 2'b00;
        #1 Reset = 1'b1;
        repeat (3) @(posedge frame_clk);
        #1;
        check("rst_pos_x", 32'(pos_x1), 32'd320);
        check("rst_pos_y", 32'(pos_y1), 32'd240);
        check("rst_vel_x", 32'(vel_x1), 32'd0);
        check("rst_state", 32'(state1), 32'd0);
        check("rst_size",  32'(size1),  32'd4);
        @(negedge frame_clk);
        Reset = 1'b0;

        // Idle with no key for 100 frames.
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pos_x1 != 10'd320 || pos_y1 != 10'd240 || vel_x1 != 10'd0 ||
                vel_y1 != 10'd0 || state1 != 2'b00)
                idle_bad++;
        end
        check("idle_100", 32'(idle_bad), 32'd0);

        // One frame of right, then release: zero latency, velocity held.
        key1 = 8'h07;
        tick();
        check("right_pos1", 32'(pos_x1), 32'd321);
        check("right_vel",  32'(vel_x1), 32'd1);
        check("right_vely", 32'(vel_y1), 32'd0);
        check("right_st",   32'(state1), 32'd1);
        key1 = 8'h00;
        tick();
        check("right_pos2", 32'(pos_x1), 32'd322);
        tick();
        check("right_pos3", 32'(pos_x1), 32'd323);

        // Space held for 10 frames: a single pause, position frozen.
        key1 = 8'h2C;
        tick();
        check("pause_st",  32'(state1), 32'd2);
        check("pause_pos", 32'(pos_x1), 32'd323);
        repeat (9) tick();
        check("pause_hold_st",  32'(state1), 32'd2);
        check("pause_hold_pos", 32'(pos_x1), 32'd323);
        key1 = 8'h04;
        repeat (3) tick();
        check("pause_key_pos", 32'(pos_x1), 32'd323);
        check("pause_key_vel", 32'(vel_x1), 32'd1);
        key1 = 8'h00;
        tick();
        key1 = 8'h2C;
        tick();
        check("resume_st",  32'(state1), 32'd1);
        check("resume_pos", 32'(pos_x1), 32'd323);
        key1 = 8'h00;
        tick();
        check("resume_step", 32'(pos_x1), 32'd324);
        check("resume_vel",  32'(vel_x1), 32'd1);

        // Stop mode, walk left to the low wall.
        mode1 = 2'b01;
        key1  = 8'h04;
        tick();
        check("left_pos", 32'(pos_x1), 32'd323);
        check("left_vel", 32'(vel_x1), 32'(V_NEG1));
        key1 = 8'h00;
        n = 0;
        while (pos_x1 != 10'd5 && n < 400) begin
            tick();
            n++;
        end
        check("stop_reach5", 32'(pos_x1), 32'd5);
        check("stop_nohit",  32'(hit_x1), 32'd0);
        tick();
        check("stop_pos", 32'(pos_x1), 32'd4);
        check("stop_vel", 32'(vel_x1), 32'd0);
        check("stop_hit", 32'(hit_x1), 32'd1);
        key1 = 8'h04;
        tick();
        check("stop_hold_pos",  32'(pos_x1), 32'd4);
        check("stop_hold_hit1", 32'(hit_x1), 32'd1);
        tick();
        check("stop_hold_hit2", 32'(hit_x1), 32'd1);
        check("stop_hold_vel",  32'(vel_x1), 32'd0);
        key1 = 8'h00;
        tick();
        check("stop_rest_hit", 32'(hit_x1), 32'd0);
        check("stop_rest_pos", 32'(pos_x1), 32'd4);

        // Step-3 instance: bounce off the right wall.
        check("d3_idle_pos", 32'(pos_x3), 32'd621);
        key3 = 8'h07;
        tick();
        check("d3_right", 32'(pos_x3), 32'd624);
        key3 = 8'h00;
        repeat (3) tick();
        check("d3_pos633", 32'(pos_x3), 32'd633);
        check("d3_pre_hit", 32'(hit_x3), 32'd0);
        tick();
        check("bounce_pos", 32'(pos_x3), 32'd635);
        check("bounce_vel", 32'(vel_x3), 32'(V_NEG3));
        check("bounce_hit", 32'(hit_x3), 32'd1);
        tick();
        check("bounce_pos2", 32'(pos_x3), 32'd632);
        check("bounce_hit2", 32'(hit_x3), 32'd0);

        // Wrap mode, moving up through the top wall.
        mode3 = 2'b10;
        key3  = 8'h1A;
        tick();
        check("up_pos_y", 32'(pos_y3), 32'd11);
        check("up_vel_x", 32'(vel_x3), 32'd0);
        check("up_vel_y", 32'(vel_y3), 32'(V_NEG3));
        key3 = 8'h00;
        repeat (2) tick();
        check("up_pos5", 32'(pos_y3), 32'd5);
        tick();
        check("wrap_pos_y", 32'(pos_y3), 32'd475);
        check("wrap_vel_y", 32'(vel_y3), 32'(V_NEG3));
        check("wrap_hit_y", 32'(hit_y3), 32'd1);
        check("wrap_hit_x", 32'(hit_x3), 32'd0);
        check("wrap_pos_x", 32'(pos_x3), 32'd632);
        tick();
        check("wrap_pos2",  32'(pos_y3), 32'd472);
        check("wrap_hit2",  32'(hit_y3), 32'd0);

        // Reset asserted between edges acts immediately.
        #2 Reset = 1'b1;
        #1;
        check("mid_rst_x",   32'(pos_x1), 32'd320);
        check("mid_rst_y",   32'(pos_y1), 32'd240);
        check("mid_rst_st",  32'(state1), 32'd0);
        check("mid_rst_vel", 32'(vel_y3), 32'd0);
        check("mid_rst_x3",  32'(pos_x3), 32'd621);
        @(negedge frame_clk);
        Reset = 1'b0;
        tick();
        check("post_rst_st",  32'(state1), 32'd0);
        check("post_rst_pos", 32'(pos_x1), 32'd320);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
